// File: rtl/core_pkg.sv
// Shared types for the RV32I core's memory stage: the access-size encoding
// (identical to the decoder's MemDataMask field) and the LSU sequencer states.
package core_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10,
    MEM_WORD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } lsu_state_t;

  // A mask of 00 carries no size information; it is handled as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] mask);
    case (mask)
      2'b01:   return MEM_BYTE;
      2'b10:   return MEM_HALF;
      default: return MEM_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store-data replication and
// misalignment detection for the incoming access, plus load-data extraction
// and sign/zero extension for the returning bus word.
module lsu_align
  import core_pkg::*;
(
  input  mem_size_t   i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misaligned,
  input  mem_size_t   i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_sign,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  // Store side: lane enables, lane-replicated data and the alignment fault.
  always_comb begin
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_misaligned = 1'b0;
    case (i_size)
      MEM_BYTE: begin
        o_be         = 4'b0001 << i_off;
        o_wdata      = {4{i_wdata[7:0]}};
        o_misaligned = 1'b0;
      end
      MEM_HALF: begin
        o_be         = 4'b0011 << {i_off[1], 1'b0};
        o_wdata      = {2{i_wdata[15:0]}};
        o_misaligned = i_off[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_wdata      = i_wdata;
        o_misaligned = |i_off;
      end
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shifted = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_size)
      MEM_BYTE: o_ld_data = {{24{i_ld_sign & w_shifted[7]}}, w_shifted[7:0]};
      MEM_HALF: o_ld_data = {{16{i_ld_sign & w_shifted[15]}}, w_shifted[15:0]};
      default:  o_ld_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// MEM-stage load/store sequencer: runs one request/response transaction on
// the data-memory bus per load/store, stalling the pipeline while it is in
// flight and reporting misaligned accesses and bus timeouts as pulses.
//
// Bus handshake: bus_req is the request valid; the request (bus_addr, bus_we,
// bus_be, bus_wdata) is accepted in a cycle where bus_req and bus_gnt are both
// high, and all request fields stay stable while bus_req is high without
// bus_gnt. Read data is taken from the first cycle with bus_rvalid high after
// the grant cycle; bus_rvalid at any other time is ignored.
module lsu_sequencer
  import core_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_data_mask,
  input  logic              mem_read_sign_extend,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misaligned,
  output logic              timeout,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output lsu_state_t        dbg_state
);

  localparam int              CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam bit              TO_EN = (MAX_WAIT > 0);
  localparam logic [CNT_W-1:0] LIMIT = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  lsu_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  mem_size_t         r_size;
  logic              r_sign;
  logic              r_we;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_bus_req;
  logic [31:0]       r_rdata;
  logic              r_rdata_valid;
  logic              r_misaligned;
  logic              r_timeout;

  logic              w_access;
  logic              w_write;
  mem_size_t         w_size;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic              w_misal;
  logic [31:0]       w_ld_data;
  logic              w_limit;
  logic              w_stall;

  assign w_access = req_valid & (mem_read | mem_write);
  assign w_write  = mem_write;
  assign w_size   = decode_size(mem_data_mask);
  // Once the limit count is reached without a completing event the access
  // is abandoned; using >= also covers a grant that lands on the limit cycle
  // followed by a read response that never arrives.
  assign w_limit  = TO_EN && (r_cnt >= LIMIT);

  lsu_align u_align (
    .i_size       (w_size),
    .i_off        (addr[1:0]),
    .i_wdata      (wdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_misaligned (w_misal),
    .i_ld_size    (r_size),
    .i_ld_off     (r_addr[1:0]),
    .i_ld_sign    (r_sign),
    .i_rdata      (bus_rdata),
    .o_ld_data    (w_ld_data)
  );

  // Stall is combinational so the pipeline freezes in the same cycle the
  // access shows up in IDLE; it is held low while reset is asserted.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      ST_IDLE:         w_stall = w_access;
      ST_REQ, ST_WAIT: w_stall = 1'b1;
      default:         w_stall = 1'b0;
    endcase
  end

  assign stall = rst_n & w_stall;

  // Transaction FSM with its latches, wait counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_be          <= '0;
      r_wdata       <= '0;
      r_size        <= MEM_WORD;
      r_sign        <= 1'b0;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      r_bus_req     <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_timeout     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_addr  <= addr;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_size  <= w_size;
            r_sign  <= mem_read_sign_extend;
            r_we    <= w_write;
            if (w_misal) begin
              r_state      <= ST_FAULT;
              r_misaligned <= 1'b1;
              r_rdata      <= '0;
            end else begin
              r_state   <= ST_REQ;
              r_bus_req <= 1'b1;
              r_cnt     <= '0;
            end
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus_gnt) begin
            r_bus_req <= 1'b0;
            r_state   <= r_we ? ST_DONE : ST_WAIT;
          end else if (w_limit) begin
            r_bus_req <= 1'b0;
            r_timeout <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_FAULT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus_rvalid) begin
            r_rdata       <= w_ld_data;
            r_rdata_valid <= 1'b1;
            r_state       <= ST_DONE;
          end else if (w_limit) begin
            r_timeout <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_FAULT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign misaligned  = r_misaligned;
  assign timeout     = r_timeout;
  assign bus_req     = r_bus_req;
  assign bus_we      = r_we;
  assign bus_addr    = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus_be      = r_be;
  assign bus_wdata   = r_wdata;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Bench for lsu_sequencer: directed accesses from the block's worked examples,
// reset during a transaction, then randomized loads/stores with random grant
// and response delays, all checked against a timeline-level reference model.
module tb_lsu_sequencer;
  import core_pkg::*;

  localparam int MAX_W  = 4;
  localparam int WINDOW = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_data_mask = 2'b00;
  logic        mem_read_sign_extend = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        misaligned;
  logic        timeout;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt = 1'b0;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  lsu_state_t  dbg_state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata = '0;
  logic [31:0] last_addr;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  int          last_stall;

  lsu_sequencer #(.ADDR_W(32), .MAX_WAIT(MAX_W)) u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .req_valid            (req_valid),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_data_mask        (mem_data_mask),
    .mem_read_sign_extend (mem_read_sign_extend),
    .addr                 (addr),
    .wdata                (wdata),
    .stall                (stall),
    .rdata                (rdata),
    .rdata_valid          (rdata_valid),
    .misaligned           (misaligned),
    .timeout              (timeout),
    .bus_req              (bus_req),
    .bus_we               (bus_we),
    .bus_addr             (bus_addr),
    .bus_be               (bus_be),
    .bus_wdata            (bus_wdata),
    .bus_gnt              (bus_gnt),
    .bus_rvalid           (bus_rvalid),
    .bus_rdata            (bus_rdata),
    .dbg_state            (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: pick the addressed bytes out of the bus word, then extend.
  function automatic logic [31:0] ext_load(input logic [31:0] w, input int off,
                                           input int nb, input logic sg);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++)
      if (off + i < 4) v = v | (32'(w[8*(off+i) +: 8]) << (8 * i));
    if (nb < 4 && sg && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // One access presented in cycle 0 of a fixed window. The slave grants in
  // cycle g+1 and answers a read in cycle g+2+r.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] mask,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input int g, input int r, input logic [31:0] rword,
                         input logic spur);
    logic        acc, is_wr, mis, to, rd_ok;
    int          nb, off, busy, ev_at, c_rd, req_exp;
    logic [3:0]  be_e;
    logic [31:0] wd_e, ld_e;
    int          stall_n, req_n, mis_n, to_n, rv_n, mis_at, to_at, rv_at;

    acc   = rd | wr;
    is_wr = wr;
    nb    = (mask == 2'b01) ? 1 : (mask == 2'b10) ? 2 : 4;
    off   = int'(a[1:0]);
    mis   = acc && (off % nb != 0);
    for (int i = 0; i < 4; i++) begin
      be_e[i]        = (i >= off) && (i < off + nb);
      wd_e[8*i +: 8] = wd[8*(i % nb) +: 8];
    end
    ld_e = ext_load(rword, off, nb, sg);

    // Walk the REQ/WAIT timeline: index j is the j-th busy cycle. The grant
    // completes a store at j==g; a read completes when its data arrives at
    // j==g+1+r. Any other busy cycle at or past MAX_W-1 ends in a timeout.
    to   = 1'b0;
    busy = 0;
    c_rd = g + 1 + r;
    if (acc && !mis) begin
      for (int j = 0; j < 32; j++) begin
        if (is_wr && j == g) begin busy = j + 1; break; end
        if (!is_wr && j == c_rd) begin busy = j + 1; break; end
        if (j != g && j >= MAX_W - 1) begin to = 1'b1; busy = j + 1; break; end
      end
    end
    ev_at   = acc ? busy + 1 : -1;
    req_exp = (acc && !mis) ? ((g + 1 < busy) ? g + 1 : busy) : 0;
    rd_ok   = acc && !mis && !is_wr && !to;
    if (rd_ok) exp_q.push_back(ld_e);
    if (acc) begin
      if (mis || to) exp_rdata = '0;
      else if (!is_wr) exp_rdata = ld_e;
    end

    stall_n = 0; req_n = 0; mis_n = 0; to_n = 0; rv_n = 0;
    mis_at = -1; to_at = -1; rv_at = -1;
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clk);
      req_valid            = (k == 0);
      mem_read             = rd;
      mem_write            = wr;
      mem_data_mask        = mask;
      mem_read_sign_extend = sg;
      addr                 = a;
      wdata                = wd;
      bus_rdata            = rword;
      bus_gnt              = (k == g + 1);
      bus_rvalid           = (!is_wr && rd && k == g + 2 + r) || (spur && k == g + 1);
      #1;
      if (stall) stall_n++;
      if (bus_req) begin
        req_n++;
        chk("bus_addr", bus_addr, {a[31:2], 2'b00});
        chk("bus_be", 32'(bus_be), 32'(be_e));
        chk("bus_we", 32'(bus_we), 32'(is_wr));
        if (is_wr) chk("bus_wdata", bus_wdata, wd_e);
        last_addr  = bus_addr;
        last_be    = bus_be;
        last_wdata = bus_wdata;
      end
      if (misaligned) begin mis_n++; mis_at = k; end
      if (timeout) begin to_n++; to_at = k; end
      if (rdata_valid) begin
        rv_n++;
        rv_at = k;
        if (exp_q.size() == 0) chk("rdata_valid_unexpected", 32'd1, 32'd0);
        else chk("rdata", rdata, exp_q.pop_front());
      end
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;

    chk("stall_cycles", stall_n, acc ? busy + 1 : 0);
    chk("req_cycles", req_n, req_exp);
    chk("misaligned_count", mis_n, mis ? 1 : 0);
    chk("misaligned_cycle", mis_at, mis ? ev_at : -1);
    chk("timeout_count", to_n, to ? 1 : 0);
    chk("timeout_cycle", to_at, to ? ev_at : -1);
    chk("rdata_valid_count", rv_n, rd_ok ? 1 : 0);
    chk("rdata_valid_cycle", rv_at, rd_ok ? ev_at : -1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("rdata_hold", rdata, exp_rdata);
    last_stall = stall_n;
  endtask

  // A word load that is interrupted by reset in cycle k_rst, then recovery.
  task automatic reset_mid(input int g, input int k_rst);
    for (int k = 0; k <= k_rst; k++) begin
      @(negedge clk);
      req_valid            = (k == 0);
      mem_read             = 1'b1;
      mem_write            = 1'b0;
      mem_data_mask        = 2'b11;
      mem_read_sign_extend = 1'b0;
      addr                 = 32'h0000_4000;
      bus_gnt              = (k == g + 1);
      bus_rvalid           = 1'b0;
      #1;
      if (rdata_valid) chk("rst_early_rdata_valid", 32'd1, 32'd0);
    end
    chk("pre_rst_stall", 32'(stall), 32'd1);
    chk("pre_rst_bus_req", 32'(bus_req), (g + 1 < k_rst) ? 32'd0 : 32'd1);
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b1;
    bus_gnt   = 1'b0;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_rvalid = (k == 0);
      #1;
      if (rdata_valid) chk("post_rst_rdata_valid", 32'd1, 32'd0);
      if (bus_req) chk("post_rst_bus_req", 32'd1, 32'd0);
    end
    bus_rvalid = 1'b0;
    chk("post_rst_rdata", rdata, 32'd0);
  endtask

  initial begin
    logic        rd, wr, sg, spur;
    logic [1:0]  mask;
    logic [31:0] a, wd, rword;
    int          kind, g, r;

    // reset state, with an access presented while reset is held
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("reset_misaligned", 32'(misaligned), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    req_valid = 1'b0;
    mem_read  = 1'b0;
    rst_n     = 1'b1;

    // sb at 0x1003, immediate grant
    run_txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h1003, 32'h0000_00A5, 0, 0, 32'h0, 1'b0);
    chk("sb_addr", last_addr, 32'h0000_1000);
    chk("sb_be", 32'(last_be), 32'h8);
    chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
    chk("sb_stall", last_stall, 2);

    // lb / lbu / lhu / lh at 0x2002
    run_txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 0, 0, 32'h1280_5634, 1'b0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_stall", last_stall, 3);
    run_txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 0, 0, 32'h1280_5634, 1'b0);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h2002, 32'h0, 0, 0, 32'hBEEF_1234, 1'b0);
    chk("lhu_rdata", rdata, 32'h0000_BEEF);
    run_txn(1'b1, 1'b0, 2'b10, 1'b1, 32'h2002, 32'h0, 0, 0, 32'hBEEF_1234, 1'b0);
    chk("lh_rdata", rdata, 32'hFFFF_BEEF);

    // misaligned lw and sh
    run_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h3001, 32'h0, 0, 0, 32'h1111_1111, 1'b0);
    chk("lw_mis_stall", last_stall, 1);
    chk("lw_mis_rdata", rdata, 32'd0);
    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h3003, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
    chk("sh_mis_stall", last_stall, 1);

    // backpressure: no grant (timeout), grant on the limit cycle (completes)
    run_txn(1'b0, 1'b1, 2'b11, 1'b0, 32'h5000, 32'hCAFE_F00D, 15, 0, 32'h0, 1'b0);
    chk("to_stall", last_stall, 5);
    run_txn(1'b0, 1'b1, 2'b11, 1'b0, 32'h5004, 32'h0BAD_BEEF, 3, 0, 32'h0, 1'b0);
    chk("limit_gnt_stall", last_stall, 5);
    run_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h5008, 32'h0, 3, 0, 32'h8765_4321, 1'b1);
    chk("limit_gnt_lw", rdata, 32'h8765_4321);
    run_txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h500C, 32'h0, 0, 0, 32'hF00D_0001, 1'b1);
    chk("mask00_word", rdata, 32'hF00D_0001);

    // reset while waiting for read data, and while requesting
    reset_mid(0, 3);
    run_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h6000, 32'h0, 1, 1, 32'h7654_3210, 1'b0);
    chk("after_rst_lw", rdata, 32'h7654_3210);
    reset_mid(5, 2);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      rd   = (kind == 1) || (kind >= 2 && kind <= 5);
      wr   = (kind == 1) || (kind >= 6);
      mask = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd   = $urandom;
      rword = $urandom;
      g    = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      r    = $urandom_range(0, 3);
      spur = 1'($urandom_range(0, 1));
      run_txn(rd, wr, mask, sg, a, wd, g, r, rword, spur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
